// File: rtl/harvard_fetch.sv
// Instruction-fetch stage: owns the PC, runs the instruction-memory read
// handshake, buffers one word for decode and applies delayed-branch redirects.
module harvard_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] HALT_ADDRESS = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] instr_address,
    output logic        instr_read,
    input  logic        instr_waitrequest,
    input  logic [31:0] instr_readdata,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        decode_ready,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    output logic        active
);

    typedef enum logic [1:0] {
        START,
        FETCH,
        HOLD,
        HALTED
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] instr_reg, instr_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] target_reg, target_next;
    logic        valid_reg, valid_next;
    logic        active_reg, active_next;
    logic        pending_reg, pending_next;
    logic [31:0] next_addr;

    // A pending redirect takes effect on the word after the delay slot.
    assign next_addr = pending_reg ? target_reg : pc_reg + 32'd4;

    always_comb begin
        state_next   = state_reg;
        addr_next    = addr_reg;
        instr_next   = instr_reg;
        pc_next      = pc_reg;
        target_next  = target_reg;
        valid_next   = valid_reg;
        active_next  = active_reg;
        pending_next = pending_reg;

        case (state_reg)
            START: begin
                state_next = FETCH;
            end
            FETCH: begin
                if (!instr_waitrequest) begin
                    instr_next = instr_readdata;
                    pc_next    = addr_reg;
                    valid_next = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (decode_ready) begin
                    valid_next = 1'b0;
                    addr_next  = next_addr;
                    // A branch sitting in a delay slot is dropped.
                    if (pending_reg) begin
                        pending_next = 1'b0;
                    end else if (branch_valid) begin
                        pending_next = 1'b1;
                        target_next  = branch_target;
                    end
                    if (next_addr == HALT_ADDRESS) begin
                        state_next  = HALTED;
                        active_next = 1'b0;
                    end else begin
                        state_next = FETCH;
                    end
                end
            end
            HALTED: begin
                state_next = HALTED;
            end
            default: begin
                state_next = START;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= START;
            addr_reg    <= RESET_VECTOR;
            instr_reg   <= 32'd0;
            pc_reg      <= 32'd0;
            target_reg  <= 32'd0;
            valid_reg   <= 1'b0;
            active_reg  <= 1'b1;
            pending_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            addr_reg    <= addr_next;
            instr_reg   <= instr_next;
            pc_reg      <= pc_next;
            target_reg  <= target_next;
            valid_reg   <= valid_next;
            active_reg  <= active_next;
            pending_reg <= pending_next;
        end
    end

    assign instr_address = addr_reg;
    assign instr_read    = (state_reg == FETCH);
    assign instruction   = instr_reg;
    assign instr_pc      = pc_reg;
    assign instr_valid   = valid_reg;
    assign active        = active_reg;

endmodule

// File: tb/tb_harvard_fetch.sv
// Directed bench for harvard_fetch: transaction-level program-flow model checked
// every cycle, plus literal expectations on delivery order, timing and reset.
module tb_harvard_fetch;

    localparam logic [31:0] RV = 32'hBFC00000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_address;
    logic        instr_read;
    logic        instr_waitrequest;
    logic [31:0] instr_readdata;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        decode_ready;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic        active;

    harvard_fetch dut (
        .clk              (clk),
        .reset            (reset),
        .instr_address    (instr_address),
        .instr_read       (instr_read),
        .instr_waitrequest(instr_waitrequest),
        .instr_readdata   (instr_readdata),
        .instruction      (instruction),
        .instr_pc         (instr_pc),
        .instr_valid      (instr_valid),
        .decode_ready     (decode_ready),
        .branch_valid     (branch_valid),
        .branch_target    (branch_target),
        .active           (active)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int wait_cnt = 0;

    // Branch plan: consuming the word at plan_pc[i] presents branch_valid with plan_tgt[i].
    logic [31:0] plan_pc  [3];
    logic [31:0] plan_tgt [3];
    int          plan_n = 0;

    // Behavioural model of program flow.
    logic        m_known = 1'b0;
    logic        m_start, m_hold, m_halted, m_pend;
    logic [31:0] m_next, m_tgt, m_word, m_pc;
    int          rd_len;

    logic [31:0] cons_pc [$];
    int          cons_cyc[$];
    logic [31:0] rd_addr [$];
    int          rd_lens [$];
    int          last_cons_cyc = -100;
    int          halt_cyc = -1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == RV) return 32'h11111111;
        return (a ^ 32'h5A5A0000) + 32'h00000013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: drive memory/branch inputs, compare against the model, advance the model.
    task automatic step();
        logic        exp_read;
        logic [31:0] n;
        if (instr_read === 1'b1 && wait_cnt > 0) begin
            instr_waitrequest = 1'b1;
            wait_cnt--;
        end else begin
            instr_waitrequest = 1'b0;
        end
        instr_readdata = (instr_read === 1'b1 && !instr_waitrequest) ? mem_word(instr_address)
                                                                      : 32'hDEADBEEF;
        if (instr_valid === 1'b1 && decode_ready && reset) begin
            branch_valid  = 1'b0;
            branch_target = 32'hFFFFFFF0;
            for (int i = 0; i < plan_n; i++) begin
                if (instr_pc == plan_pc[i]) begin
                    branch_valid  = 1'b1;
                    branch_target = plan_tgt[i];
                end
            end
        end else begin
            // Branch noise outside consume cycles; taking it would halt the core.
            branch_valid  = 1'b1;
            branch_target = 32'h00000000;
        end

        if (m_known) begin
            exp_read = !m_hold && !m_halted && !m_start;
            chk("active", active, !m_halted);
            chk("instr_read", instr_read, exp_read);
            chk("instr_valid", instr_valid, m_hold);
            if (exp_read) chk("instr_address", instr_address, m_next);
            if (m_hold) begin
                chk("instruction", instruction, m_word);
                chk("instr_pc", instr_pc, m_pc);
            end
            if (active === 1'b0 && halt_cyc < 0) halt_cyc = cyc;
        end

        if (!reset) begin
            m_known = 1'b1; m_start = 1'b1; m_hold = 1'b0; m_halted = 1'b0;
            m_pend = 1'b0; m_tgt = 32'd0; m_next = RV; m_word = 32'd0; m_pc = 32'd0;
            rd_len = 0;
        end else if (!m_known || m_halted) begin
            // nothing moves
        end else if (m_start) begin
            m_start = 1'b0;
        end else if (m_hold) begin
            if (decode_ready) begin
                $display("consume pc=%h instr=%h branch=%0b target=%h",
                         m_pc, m_word, branch_valid, branch_target);
                cons_pc.push_back(m_pc);
                cons_cyc.push_back(cyc);
                if (m_pend) begin
                    n = m_tgt;
                    m_pend = 1'b0;
                end else begin
                    n = m_pc + 32'd4;
                    if (branch_valid) begin
                        m_pend = 1'b1;
                        m_tgt  = branch_target;
                    end
                end
                m_hold = 1'b0;
                m_next = n;
                if (n == 32'd0) begin
                    m_halted = 1'b1;
                    last_cons_cyc = cyc;
                end
            end
        end else begin
            rd_len++;
            if (!instr_waitrequest) begin
                rd_addr.push_back(m_next);
                rd_lens.push_back(rd_len);
                rd_len = 0;
                m_hold = 1'b1;
                m_word = mem_word(m_next);
                m_pc   = m_next;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    logic [31:0] exp_seq [7];

    initial begin
        exp_seq[0] = 32'hBFC00000; exp_seq[1] = 32'hBFC00004; exp_seq[2] = 32'hBFC00008;
        exp_seq[3] = 32'hBFC0000C; exp_seq[4] = 32'hBFC00100; exp_seq[5] = 32'hBFC00104;
        exp_seq[6] = 32'hBFC00108;
        plan_pc[0] = 32'hBFC00008; plan_tgt[0] = 32'hBFC00100;
        plan_pc[1] = 32'hBFC0000C; plan_tgt[1] = 32'h12345678;
        plan_pc[2] = 32'hBFC00104; plan_tgt[2] = 32'h00000000;

        reset = 1'b0; decode_ready = 1'b0; branch_valid = 1'b0; branch_target = 32'd0;
        instr_waitrequest = 1'b0; instr_readdata = 32'd0;
        @(negedge clk);
        step(); step();
        chk("rst_read", instr_read, 1'b0);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_address", instr_address, RV);
        chk("rst_active", active, 1'b1);
        chk("rst_instruction", instruction, 32'd0);
        chk("rst_pc", instr_pc, 32'd0);

        // Release: one START cycle, then the first read.
        reset = 1'b1;
        step();
        chk("first_read", instr_read, 1'b1);
        chk("first_address", instr_address, RV);
        step();
        chk("first_word", instruction, 32'h11111111);
        chk("first_pc", instr_pc, RV);
        chk("first_valid", instr_valid, 1'b1);

        // Backpressure for 5 cycles.
        repeat (5) step();
        chk("bp_word", instruction, 32'h11111111);
        chk("bp_read", instr_read, 1'b0);

        // Consume; the read of 0xBFC00004 then stalls for 3 cycles.
        decode_ready = 1'b1;
        wait_cnt = 3;
        plan_n = 3;
        step();
        chk("post_consume_read", instr_read, 1'b1);
        chk("post_consume_addr", instr_address, 32'hBFC00004);

        for (int i = 0; i < 200 && !m_halted; i++) step();
        repeat (8) step();
        chk("halted_active", active, 1'b0);
        chk("halted_read", instr_read, 1'b0);

        chk("n_consumes", cons_pc.size(), 32'd7);
        chk("n_reads", rd_addr.size(), 32'd7);
        for (int i = 0; i < 7; i++) begin
            if (i < cons_pc.size()) chk($sformatf("consume_pc[%0d]", i), cons_pc[i], exp_seq[i]);
            if (i < rd_addr.size()) begin
                chk($sformatf("read_addr[%0d]", i), rd_addr[i], exp_seq[i]);
                chk($sformatf("read_len[%0d]", i), rd_lens[i], (i == 1) ? 32'd4 : 32'd1);
            end
        end
        for (int i = 2; i < 7; i++) begin
            if (i < cons_cyc.size())
                chk($sformatf("consume_gap[%0d]", i), cons_cyc[i] - cons_cyc[i-1], 32'd2);
        end
        chk("halt_latency", halt_cyc - last_cons_cyc, 32'd1);

        // Reset in the middle of a stalled read.
        reset = 1'b0;
        step();
        reset = 1'b1; decode_ready = 1'b0;
        step();
        wait_cnt = 100;
        step(); step();
        chk("stall_read", instr_read, 1'b1);
        reset = 1'b0;
        step();
        chk("midrst_read", instr_read, 1'b0);
        chk("midrst_valid", instr_valid, 1'b0);
        chk("midrst_address", instr_address, RV);
        chk("midrst_active", active, 1'b1);
        wait_cnt = 0;
        reset = 1'b1;
        step(); step(); step();
        chk("refetch_word", instruction, 32'h11111111);
        chk("refetch_pc", instr_pc, RV);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
